// File: rtl/baud_rate_generator.sv
// -----------------------------------------------------------------------------
// baud_rate_generator
//
// Runtime-programmable baud tick generator for the UART Tx and Rx paths.
// clk is divided by an integer+fractional divisor to give the oversample
// strobe os_tick. os_tick is divided by OVERSAMPLE to give the bit strobe
// baud_tick. The divisor is reloaded through a load/ack handshake. A new
// divisor only takes effect on an interval boundary, so the running period is
// never glitched.
//
// Optional feature macro: BAUD_GEN_FRAC_EN
//   defined     : the fractional accumulator is built. The long-run os_tick
//                 period is div_int + div_frac/2^FRAC_WIDTH clk cycles.
//   not defined : the interval is exactly max(div_int,2) cycles. The div_frac
//                 port and DEFAULT_FRAC are ignored.
//
// Ports
//   clk        in   system clock, all logic on posedge
//   reset_n    in   synchronous reset, active low
//   enable     in   1 = run; 0 = counters held cleared, no ticks
//   div_int    in   requested integer divisor (clk cycles per os_tick)
//   div_frac   in   requested fractional divisor (1 LSB = 1/2^FRAC_WIDTH clk)
//   div_load   in   1-cycle request to capture div_int/div_frac
//   div_ack    out  1-cycle pulse, the cycle after div_load is sampled
//   os_tick    out  oversample strobe, single-cycle pulse
//   baud_tick  out  bit strobe, coincident with the os_tick that wraps os_phase
//   os_phase   out  index of the current oversample slot in the bit
// -----------------------------------------------------------------------------
module baud_rate_generator #(
  parameter int DIV_WIDTH    = 16,
  parameter int FRAC_WIDTH   = 4,
  parameter int OVERSAMPLE   = 16,
  parameter int DEFAULT_DIV  = 312,
  parameter int DEFAULT_FRAC = 8,
  localparam int PHASE_W     = $clog2(OVERSAMPLE)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic [DIV_WIDTH-1:0]  div_int,
  input  logic [FRAC_WIDTH-1:0] div_frac,
  input  logic                  div_load,
  output logic                  div_ack,
  output logic                  os_tick,
  output logic                  baud_tick,
  output logic [PHASE_W-1:0]    os_phase
);

  // The counter needs one extra bit, because a carry can lengthen the
  // largest divisor by one cycle.
  localparam int CNT_W = DIV_WIDTH + 1;

  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0] div_act_q, div_act_d;
  logic [DIV_WIDTH-1:0] div_sh_q, div_sh_d;
  logic                 pending_q, pending_d;
  logic                 ack_q, ack_d;
  logic                 os_tick_q, os_tick_d;
  logic                 baud_tick_q, baud_tick_d;
  logic [PHASE_W-1:0]   phase_q, phase_d;

  logic                 carry;
  logic [CNT_W-1:0]     div_eff;
  logic [CNT_W-1:0]     period_last;
  logic                 terminal;
  logic                 load_now;

  // A divisor of 0 or 1 is clamped to 2. This keeps os_tick from being high
  // on two consecutive cycles.
  assign div_eff     = (div_act_q < DIV_WIDTH'(2)) ? CNT_W'(2) : {1'b0, div_act_q};
  assign period_last = div_eff + CNT_W'(carry) - CNT_W'(1);
  assign terminal    = enable && (cnt_q == period_last);

  // A divisor change lands only on an interval boundary. While the generator
  // is idle there is no running interval to protect, so the change applies at
  // once.
  assign load_now = !enable || terminal;

  // ---------------------------------------------------------------------------
  // Divisor shadow / active registers and the load handshake
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: give every always_comb output a default first. A path that leaves
    // a signal unassigned would infer a latch.
    div_act_d = div_act_q;
    div_sh_d  = div_sh_q;
    pending_d = pending_q;
    ack_d     = div_load;

    if (div_load) div_sh_d = div_int;

    if (load_now) begin
      // A load that arrives on the terminal cycle itself bypasses the shadow.
      // It then governs the interval that starts next.
      if (div_load)       div_act_d = div_int;
      else if (pending_q) div_act_d = div_sh_q;
      pending_d = 1'b0;
    end else if (div_load) begin
      pending_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Interval counter, oversample phase and tick generation
  // ---------------------------------------------------------------------------
  always_comb begin
    cnt_d       = cnt_q + CNT_W'(1);
    phase_d     = phase_q;
    os_tick_d   = 1'b0;
    baud_tick_d = 1'b0;

    if (!enable) begin
      cnt_d   = '0;
      phase_d = '0;
    end else if (terminal) begin
      cnt_d       = '0;
      os_tick_d   = 1'b1;
      baud_tick_d = (phase_q == PHASE_W'(OVERSAMPLE - 1));
      phase_d     = (phase_q == PHASE_W'(OVERSAMPLE - 1)) ? '0 : phase_q + PHASE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only. Every
    // register then samples pre-edge values, whatever the order of the
    // statements.
    if (!reset_n) begin
      cnt_q       <= '0;
      div_act_q   <= DIV_WIDTH'(DEFAULT_DIV);
      div_sh_q    <= DIV_WIDTH'(DEFAULT_DIV);
      pending_q   <= 1'b0;
      ack_q       <= 1'b0;
      os_tick_q   <= 1'b0;
      baud_tick_q <= 1'b0;
      phase_q     <= '0;
    end else begin
      cnt_q       <= cnt_d;
      div_act_q   <= div_act_d;
      div_sh_q    <= div_sh_d;
      pending_q   <= pending_d;
      ack_q       <= ack_d;
      os_tick_q   <= os_tick_d;
      baud_tick_q <= baud_tick_d;
      phase_q     <= phase_d;
    end
  end

`ifdef BAUD_GEN_FRAC_EN
  // ---------------------------------------------------------------------------
  // Fractional accumulator. Its carry adds one cycle to the NEXT interval.
  // ---------------------------------------------------------------------------
  logic [FRAC_WIDTH-1:0] acc_q, acc_d;
  logic [FRAC_WIDTH-1:0] frac_act_q, frac_act_d;
  logic [FRAC_WIDTH-1:0] frac_sh_q, frac_sh_d;
  logic                  carry_q, carry_d;

  assign carry = carry_q;

  always_comb begin
    acc_d      = acc_q;
    carry_d    = carry_q;
    frac_act_d = frac_act_q;
    frac_sh_d  = frac_sh_q;

    if (div_load) frac_sh_d = div_frac;
    if (load_now) begin
      if (div_load)       frac_act_d = div_frac;
      else if (pending_q) frac_act_d = frac_sh_q;
    end

    if (!enable) begin
      acc_d   = '0;
      carry_d = 1'b0;
    end else if (terminal) begin
      {carry_d, acc_d} = {1'b0, acc_q} + {1'b0, frac_act_q};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc_q      <= '0;
      carry_q    <= 1'b0;
      frac_act_q <= FRAC_WIDTH'(DEFAULT_FRAC);
      frac_sh_q  <= FRAC_WIDTH'(DEFAULT_FRAC);
    end else begin
      acc_q      <= acc_d;
      carry_q    <= carry_d;
      frac_act_q <= frac_act_d;
      frac_sh_q  <= frac_sh_d;
    end
  end
`else
  // Integer-only build: intervals are exact and div_frac is ignored.
  logic unused_frac;
  assign carry       = 1'b0;
  assign unused_frac = ^{div_frac, FRAC_WIDTH'(DEFAULT_FRAC)};
`endif

  assign div_ack   = ack_q;
  assign os_tick   = os_tick_q;
  assign baud_tick = baud_tick_q;
  assign os_phase  = phase_q;

endmodule

// File: tb/tb_baud_rate_generator.sv
// -----------------------------------------------------------------------------
// tb_baud_rate_generator
//
// Directed bench for baud_rate_generator with OVERSAMPLE=4 and FRAC_WIDTH=4.
// Inputs are driven and outputs are sampled on the falling edge. Interval
// lengths are counted in clock cycles between os_tick samples.
// -----------------------------------------------------------------------------
module tb_baud_rate_generator;

  localparam int DIV_WIDTH  = 16;
  localparam int FRAC_WIDTH = 4;
  localparam int OVERSAMPLE = 4;
  localparam int PHASE_W    = $clog2(OVERSAMPLE);

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic                  enable;
  logic [DIV_WIDTH-1:0]  div_int;
  logic [FRAC_WIDTH-1:0] div_frac;
  logic                  div_load;
  logic                  div_ack;
  logic                  os_tick;
  logic                  baud_tick;
  logic [PHASE_W-1:0]    os_phase;

  int n_vec  = 0;
  int n_miss = 0;

  baud_rate_generator #(
    .DIV_WIDTH   (DIV_WIDTH),
    .FRAC_WIDTH  (FRAC_WIDTH),
    .OVERSAMPLE  (OVERSAMPLE),
    .DEFAULT_DIV (312),
    .DEFAULT_FRAC(8)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .enable   (enable),
    .div_int  (div_int),
    .div_frac (div_frac),
    .div_load (div_load),
    .div_ack  (div_ack),
    .os_tick  (os_tick),
    .baud_tick(baud_tick),
    .os_phase (os_phase)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Counts falling edges until os_tick is seen high. The count is bounded.
  task automatic wait_tick(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!os_tick && n < 1000);
    check("tick_seen", int'(os_tick), 1);
  endtask

  // Pulses div_load for one cycle and checks the ack handshake.
  task automatic load_div(input int i, input int f, input string tag);
    div_int  = DIV_WIDTH'(i);
    div_frac = FRAC_WIDTH'(f);
    div_load = 1'b1;
    step();
    div_load = 1'b0;
    check({tag, "_ack_hi"}, int'(div_ack), 1);
    step();
    check({tag, "_ack_lo"}, int'(div_ack), 0);
  endtask

  initial begin
    int n, sum, adj;
    logic prev;

    reset_n  = 1'b0;
    enable   = 1'b0;
    div_int  = '0;
    div_frac = '0;
    div_load = 1'b0;
    repeat (3) step();
    check("rst_os_tick",   int'(os_tick),   0);
    check("rst_baud_tick", int'(baud_tick), 0);
    check("rst_div_ack",   int'(div_ack),   0);
    check("rst_os_phase",  int'(os_phase),  0);
    reset_n = 1'b1;
    step();

    // 1: divisor 3/0 gives an os_tick every 3 cycles. os_phase runs 1,2,3,0.
    //    baud_tick comes on the wrap.
    load_div(3, 0, "t1");
    enable = 1'b1;
    wait_tick(n);
    check("t1_first", n, 3);
    check("t1_phase1", int'(os_phase), 1);
    check("t1_baud_lo", int'(baud_tick), 0);
    wait_tick(n);
    check("t1_int2", n, 3);
    check("t1_phase2", int'(os_phase), 2);
    wait_tick(n);
    check("t1_int3", n, 3);
    check("t1_phase3", int'(os_phase), 3);
    wait_tick(n);
    check("t1_int4", n, 3);
    check("t1_phase0", int'(os_phase), 0);
    check("t1_baud_hi", int'(baud_tick), 1);
    step();
    check("t1_baud_pulse", int'(baud_tick), 0);
    sum = 1;
    do begin step(); sum++; end while (!baud_tick && sum < 100);
    check("t1_baud_period", sum, 12);

    // 6: drop enable at os_phase=2. Ticks stop and os_phase clears. After
    //    re-enable the first tick comes P cycles later.
    wait_tick(n);
    wait_tick(n);
    check("t6_at_phase2", int'(os_phase), 2);
    enable = 1'b0;
    adj = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (os_tick || baud_tick) adj++;
    end
    check("t6_no_ticks", adj, 0);
    check("t6_phase_clr", int'(os_phase), 0);
    enable = 1'b1;
    wait_tick(n);
    check("t6_first", n, 3);
    check("t6_phase1", int'(os_phase), 1);

    // 2: divisor 3/8. With the accumulator built, the intervals are 3,3,4,3,4.
    enable = 1'b0;
    step();
    load_div(3, 8, "t2");
    enable = 1'b1;
    wait_tick(n);
    check("t2_first", n, 3);
    sum = 0;
    for (int i = 0; i < 4; i++) begin
      wait_tick(n);
`ifdef BAUD_GEN_FRAC_EN
      check($sformatf("t2_int%0d", i), n, (i == 1 || i == 3) ? 4 : 3);
`else
      check($sformatf("t2_int%0d", i), n, 3);
`endif
      sum += n;
    end
`ifdef BAUD_GEN_FRAC_EN
    check("t2_four_sum", sum, 14);
`else
    check("t2_four_sum", sum, 12);
`endif

    // 3: loads of 0 then 1 back-to-back. Both are acked, the last one wins,
    //    and the clamp gives 2-cycle intervals.
    enable   = 1'b0;
    step();
    div_int  = 16'd0;
    div_frac = 4'd0;
    div_load = 1'b1;
    step();
    check("t3_ack_a", int'(div_ack), 1);
    div_int = 16'd1;
    step();
    check("t3_ack_b", int'(div_ack), 1);
    div_load = 1'b0;
    step();
    check("t3_ack_lo", int'(div_ack), 0);
    enable = 1'b1;
    wait_tick(n);
    check("t3_first", n, 2);
    for (int i = 0; i < 4; i++) begin
      wait_tick(n);
      check($sformatf("t3_int%0d", i), n, 2);
    end
    adj  = 0;
    prev = os_tick;
    for (int i = 0; i < 20; i++) begin
      step();
      if (prev && os_tick) adj++;
      prev = os_tick;
    end
    check("t3_adjacent", adj, 0);

    // 4: running at 10, load 5 while cnt=2. The current interval still ends
    //    at 10, and the intervals after it are 5.
    enable = 1'b0;
    step();
    load_div(10, 0, "t4a");
    enable = 1'b1;
    wait_tick(n);
    check("t4_first", n, 10);
    n = 0;
    do begin
      step();
      n++;
      if (n == 2) begin
        div_int  = 16'd5;
        div_load = 1'b1;
      end else if (n == 3) begin
        div_load = 1'b0;
        check("t4_ack", int'(div_ack), 1);
      end
    end while (!os_tick && n < 100);
    check("t4_cur_int", n, 10);
    wait_tick(n);
    check("t4_new_int1", n, 5);
    wait_tick(n);
    check("t4_new_int2", n, 5);

    // 5: reset mid-interval with a load pending. All outputs clear, the
    //    divisor returns to 312 and the pending load is dropped.
    step();
    step();
    div_int  = 16'd7;
    div_load = 1'b1;
    step();
    div_load = 1'b0;
    reset_n  = 1'b0;
    step();
    check("t5_ack_clr",   int'(div_ack),   0);
    check("t5_os_clr",    int'(os_tick),   0);
    check("t5_baud_clr",  int'(baud_tick), 0);
    check("t5_phase_clr", int'(os_phase),  0);
    reset_n = 1'b1;
    wait_tick(n);
    check("t5_default_div", n, 312);
    check("t5_phase1", int'(os_phase), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
